// File: rtl/multiplier_cycle_counter.sv
// Iteration down-counter for the shift-add multiplier: preset to N-1, saturating decrement.
// Optional sticky underflow flag when MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN is defined.
module multiplier_cycle_counter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         do_preset,
  input  logic         do_decrement,
  output logic [W-1:0] count,
  output logic         is_zero,
  output logic         is_last
`ifdef MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN
  ,
  output logic         underflow
`endif
);

  localparam logic [W-1:0] PRESET = W'(N - 1);
  localparam logic [W-1:0] ONE    = W'(1);

  logic [W-1:0] count_nxt;

  // Preset dominates decrement; decrement saturates at zero.
  always_comb begin
    count_nxt = count;
    if (do_preset)
      count_nxt = PRESET;
    else if (do_decrement && !is_zero)
      count_nxt = count - ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else       count <= count_nxt;
  end

  assign is_zero = (count == '0);
  assign is_last = (count == ONE);

`ifdef MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN
  always_ff @(posedge clock) begin
    if (reset || do_preset)
      underflow <= 1'b0;
    else if (do_decrement && is_zero)
      underflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_multiplier_cycle_counter.sv
// Self-checking bench: N=4 and N=8 counters share stimulus and are checked against an integer model.
module tb_multiplier_cycle_counter;

  logic       clock = 1'b0;
  logic       reset = 1'b0, do_preset = 1'b0, do_decrement = 1'b0;
  logic [1:0] count4;
  logic       z4, l4;
  logic [2:0] count8;
  logic       z8, l8;
`ifdef MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN
  logic       uf4, uf8;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int m4 = 0, m8 = 0;
  int mu4 = 0, mu8 = 0;

  always #5 clock = ~clock;

  multiplier_cycle_counter #(.N(4)) dut4 (
    .clock(clock), .reset(reset), .do_preset(do_preset), .do_decrement(do_decrement),
    .count(count4), .is_zero(z4), .is_last(l4)
`ifdef MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN
    , .underflow(uf4)
`endif
  );

  multiplier_cycle_counter #(.N(8)) dut8 (
    .clock(clock), .reset(reset), .do_preset(do_preset), .do_decrement(do_decrement),
    .count(count8), .is_zero(z8), .is_last(l8)
`ifdef MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN
    , .underflow(uf8)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int nxt(input int m, input int n, input bit r, input bit p, input bit d);
    if (r)               return 0;
    if (p)               return n - 1;
    if (d && m > 0)      return m - 1;
    return m;
  endfunction

  function automatic int nxt_uf(input int u, input int m, input bit r, input bit p, input bit d);
    if (r || p)          return 0;
    if (d && m == 0)     return 1;
    return u;
  endfunction

  task automatic step(input bit r, input bit p, input bit d);
    reset = r; do_preset = p; do_decrement = d;
    @(posedge clock);
    mu4 = nxt_uf(mu4, m4, r, p, d);
    mu8 = nxt_uf(mu8, m8, r, p, d);
    m4  = nxt(m4, 4, r, p, d);
    m8  = nxt(m8, 8, r, p, d);
    #1;
    chk("count4", 32'(count4), m4);
    chk("zero4",  32'(z4), (m4 == 0) ? 1 : 0);
    chk("last4",  32'(l4), (m4 == 1) ? 1 : 0);
    chk("count8", 32'(count8), m8);
    chk("zero8",  32'(z8), (m8 == 0) ? 1 : 0);
    chk("last8",  32'(l8), (m8 == 1) ? 1 : 0);
`ifdef MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN
    chk("uf4", 32'(uf4), mu4);
    chk("uf8", 32'(uf8), mu8);
`endif
  endtask

  initial begin
    // reset held with both controls asserted
    repeat (2) begin
      step(1, 1, 1);
      chk("rst_count", 32'(count4), 0);
      chk("rst_zero", 32'(z4), 1);
    end
    step(0, 0, 0);
    chk("rst_release", 32'(count4), 0);

    // full sequence N=4
    step(0, 1, 0);
    chk("seq_preset", 32'(count4), 3);
    chk("seq_nz", 32'(z4), 0);
    step(0, 0, 1); chk("seq_2", 32'(count4), 2);
    step(0, 0, 1); chk("seq_1", 32'(count4), 1); chk("seq_last", 32'(l4), 1);
    step(0, 0, 1); chk("seq_0", 32'(count4), 0); chk("seq_zero", 32'(z4), 1);

    // saturation at zero
    step(0, 0, 1); chk("sat_a", 32'(count4), 0);
`ifdef MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN
    chk("uf_set", 32'(uf4), 1);
`endif
    step(0, 0, 1); chk("sat_b", 32'(count4), 0); chk("sat_zero", 32'(z4), 1);
`ifdef MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN
    chk("uf_sticky", 32'(uf4), 1);
`endif
    step(0, 1, 0); chk("sat_preset", 32'(count4), 3);
`ifdef MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN
    chk("uf_clr", 32'(uf4), 0);
`endif

    // priority
    step(0, 0, 1); step(0, 0, 1);
    chk("pri_at1", 32'(count4), 1);
    step(0, 1, 1); chk("pri_preset", 32'(count4), 3);
    step(0, 0, 1); chk("pri_at2", 32'(count4), 2);
    step(1, 1, 0); chk("pri_reset", 32'(count4), 0);

    // mid-sequence restart N=8
    step(0, 1, 0); chk("rs_7", 32'(count8), 7);
    step(0, 0, 1); step(0, 0, 1); chk("rs_5", 32'(count8), 5);
    step(0, 1, 0); chk("rs_7b", 32'(count8), 7);
    for (int i = 6; i >= 0; i--) begin
      step(0, 0, 1);
      chk("rs_dec", 32'(count8), i);
      chk("rs_last", 32'(l8), (i == 1) ? 1 : 0);
    end

    // hold
    step(0, 1, 0); step(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0);
      chk("hold_cnt", 32'(count4), 2);
      chk("hold_nz", 32'(z4), 0);
    end

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(31) == 0, $urandom_range(7) == 0, $urandom_range(1) == 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multiplier_cycle_counter.md
# multiplier_cycle_counter

Down-counter that sequences the iterative shift-add multiplier. The controller presets it to N−1 at the start of a multiplication and decrements it once per datapath step. The counter flags when the final iteration has been reached, so the controller knows when to finish. It sits beside the multiplier datapath register and is driven only by the multiplier control FSM.

## Interface

Parameters:
- N, default 4: datapath width in bits, i.e. the number of multiplier iterations. Legal range N ≥ 2.
- W, default $clog2(N): width of the count register. Derived; not overridden.

Ports:
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: reset is synchronous and active-high; it clears the counter on the next rising clock edge.
- do_preset, input, 1: load count with N−1 at the next edge.
- do_decrement, input, 1: subtract 1 from count at the next edge.
- count, output, W: current counter value, driven directly from the register.
- is_zero, output, 1: high when count == 0.
- is_last, output, 1: high when count == 1.
- underflow, output, 1: present only when MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN is defined.

## Operation

- State is one W-bit register, count.
- Next-state priority, highest first:
  1. reset: count ← 0.
  2. do_preset: count ← N−1. This holds even if do_decrement is also high.
  3. do_decrement with count ≠ 0: count ← count − 1.
  4. do_decrement with count == 0: count holds at 0. It saturates and never wraps to 2^W−1.
  5. Otherwise count holds.
- is_zero and is_last are purely combinational decodes of the count register. There is no input-to-output combinational path.
- Arithmetic is unsigned and W bits wide. The preset constant N−1 is truncated to W bits, which always fits.
- Presetting while already counting restarts the sequence at N−1.

## Timing

- Reset values: count = 0, is_zero = 1, is_last = 0, underflow = 0 (when present).
- Latency is one cycle: an input sampled at edge k is reflected on count, is_zero and is_last immediately after edge k.
- For a multiply starting with a preset at edge 0 and decrements at edges 1..N−1:
  - count is N−1, N−2, …, 0.
  - is_zero first rises after edge N−1.
- Reset applied mid-sequence wins at its edge. Count returns to 0 regardless of do_preset or do_decrement.
- Inputs have no handshake. They are level-sampled every edge, so holding do_decrement high decrements on every edge until zero is reached, then saturates.

## Configuration

- MULTIPLIER_CYCLE_COUNTER_UNDERFLOW_EN defined:
  - Adds the 1-bit output underflow, a sticky error flag.
  - It is set at the edge where do_decrement is high, do_preset is low and count == 0.
  - It is cleared by reset or by do_preset.
  - It is registered, with reset value 0.
  - The count behaviour itself is unchanged (it still saturates).
- Macro undefined:
  - No underflow port and no associated logic.
  - Decrement at zero is silently ignored.

## Test plan

- Reset: hold reset high for 2 edges with do_preset = 1 and do_decrement = 1 → count = 0 and is_zero = 1 after each edge. Release reset with inputs low → count stays 0.
- Full sequence, N = 4: preset for one edge → count = 3, is_zero = 0. Then decrement for 3 edges → count 2, 1 (is_last = 1), 0 (is_zero = 1).
- Saturation, N = 4: from count = 0, decrement for 2 edges → count stays 0, is_zero = 1. With the macro defined, underflow = 1 after the first such edge and stays 1. A subsequent preset clears it and gives count = 3.
- Priority: at count = 1, assert do_preset and do_decrement together → count = 3 (preset wins). With count = 2, assert reset and do_preset together → count = 0.
- Mid-sequence restart, N = 8 (W = 3): preset → 7, decrement twice → 5, preset → 7, decrement 7 times → 0, with is_last high only when count = 1.
- Hold: with count = 2, keep both inputs low for 5 edges → count remains 2 and is_zero = 0 throughout.
